// File: rtl/cpu_exec_ctrl.sv
// Execution sequencer for the RISC-V core: core reset/clock-enable, run/step/halt, cycle counter, watchdog.
// Optional breakpoint support is compiled in with `define CPU_EXEC_CTRL_BKPT_EN.
module cpu_exec_ctrl #(
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned MAX_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_mode,
  input  logic             step_req,
  input  logic             restart,
  input  logic             halt,
`ifdef CPU_EXEC_CTRL_BKPT_EN
  input  logic             bkpt_en,
  input  logic [31:0]      bkpt_addr,
  input  logic [31:0]      pc,
  output logic             bkpt_hit,
`endif
  output logic             core_rst,
  output logic             core_en,
  output logic [1:0]       state,
  output logic             halted,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    S_RESET = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_HALT  = 2'b11
  } state_t;

  localparam int unsigned        RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0]    RC_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   WD_LAST = (MAX_CYCLES > 0) ? CNT_W'(MAX_CYCLES - 1) : '0;

  state_t           st, st_nx;
  logic [RC_W-1:0]  rst_cnt, rst_cnt_nx;
  logic             step_q, step_edge, wd_fire;
  logic             core_en_nx, timeout_nx;
  logic [CNT_W-1:0] cnt_nx;
`ifdef CPU_EXEC_CTRL_BKPT_EN
  logic             bkpt_hit_nx;
`endif

  assign state = st;

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= S_RESET;
      rst_cnt   <= '0;
      step_q    <= 1'b0;
      core_rst  <= 1'b1;
      core_en   <= 1'b0;
      halted    <= 1'b0;
      timeout   <= 1'b0;
      cycle_cnt <= '0;
`ifdef CPU_EXEC_CTRL_BKPT_EN
      bkpt_hit  <= 1'b0;
`endif
    end else begin
      st        <= st_nx;
      rst_cnt   <= rst_cnt_nx;
      step_q    <= step_req;
      core_rst  <= (st_nx == S_RESET);
      core_en   <= core_en_nx;
      halted    <= (st_nx == S_HALT);
      timeout   <= timeout_nx;
      cycle_cnt <= cnt_nx;
`ifdef CPU_EXEC_CTRL_BKPT_EN
      bkpt_hit  <= bkpt_hit_nx;
`endif
    end
  end

  // Outputs are registered from the next state, so core_rst/core_en/halted
  // change in the same cycle the new state becomes visible.
  always_comb begin
    step_edge  = step_req & ~step_q;
    wd_fire    = (MAX_CYCLES != 0) && core_en && (cycle_cnt == WD_LAST);
    st_nx      = st;
    rst_cnt_nx = '0;
    core_en_nx = 1'b0;
    timeout_nx = timeout;
    cnt_nx     = (core_en && (cycle_cnt != '1)) ? cycle_cnt + CNT_W'(1) : cycle_cnt;
`ifdef CPU_EXEC_CTRL_BKPT_EN
    bkpt_hit_nx = bkpt_hit;
`endif

    if (restart) begin
      st_nx = S_RESET;
    end else if (wd_fire) begin
      st_nx      = S_HALT;
      timeout_nx = 1'b1;
    end else if (core_en && halt) begin
      st_nx = S_HALT;
    end else begin
      case (st)
        S_RESET: begin
          if (rst_cnt == RC_LAST) st_nx = run_mode ? S_RUN : S_PAUSE;
          else                    rst_cnt_nx = rst_cnt + RC_W'(1);
        end
        S_RUN: begin
`ifdef CPU_EXEC_CTRL_BKPT_EN
          if (core_en && bkpt_en && (pc == bkpt_addr)) begin
            st_nx       = S_PAUSE;
            bkpt_hit_nx = 1'b1;
          end else
`endif
          if (!run_mode) st_nx = S_PAUSE;
        end
        S_PAUSE: begin
          if (run_mode)       st_nx = S_RUN;
          else if (step_edge) core_en_nx = 1'b1;
        end
        default: ;
      endcase
    end

    if (st_nx == S_RUN) core_en_nx = 1'b1;
    if (st_nx == S_RESET) begin
      cnt_nx     = '0;
      timeout_nx = 1'b0;
`ifdef CPU_EXEC_CTRL_BKPT_EN
      bkpt_hit_nx = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// Directed self-checking bench for cpu_exec_ctrl: reset, run, halt, step, watchdog, saturation, collisions.
module tb_cpu_exec_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, run_mode = 1'b1, step_req = 1'b0, restart = 1'b0, halt = 1'b0;
  logic core_rst, core_en, halted, timeout;
  logic [1:0]  state;
  logic [31:0] cycle_cnt;
  logic s_core_rst, s_core_en, s_halted, s_timeout;
  logic [1:0]  s_state;
  logic [2:0]  s_cycle_cnt;
  int total = 0, bad = 0;
  int n;

`ifdef CPU_EXEC_CTRL_BKPT_EN
  logic        bkpt_en = 1'b0, bkpt_hit, s_bkpt_hit;
  logic [31:0] bkpt_addr = 32'h10;
  logic [31:0] pc;
  assign pc = {cycle_cnt[29:0], 2'b00};
`endif

  cpu_exec_ctrl #(.RST_CYCLES(4), .CNT_W(32), .MAX_CYCLES(20)) u_dut (
    .clk(clk), .rst(rst), .run_mode(run_mode), .step_req(step_req),
    .restart(restart), .halt(halt),
`ifdef CPU_EXEC_CTRL_BKPT_EN
    .bkpt_en(bkpt_en), .bkpt_addr(bkpt_addr), .pc(pc), .bkpt_hit(bkpt_hit),
`endif
    .core_rst(core_rst), .core_en(core_en), .state(state), .halted(halted),
    .timeout(timeout), .cycle_cnt(cycle_cnt)
  );

  // Narrow counter, watchdog disabled: exercises saturation and MAX_CYCLES=0.
  cpu_exec_ctrl #(.RST_CYCLES(4), .CNT_W(3), .MAX_CYCLES(0)) u_sat (
    .clk(clk), .rst(rst), .run_mode(run_mode), .step_req(step_req),
    .restart(restart), .halt(halt),
`ifdef CPU_EXEC_CTRL_BKPT_EN
    .bkpt_en(1'b0), .bkpt_addr(32'h0), .pc(32'h0), .bkpt_hit(s_bkpt_hit),
`endif
    .core_rst(s_core_rst), .core_en(s_core_en), .state(s_state), .halted(s_halted),
    .timeout(s_timeout), .cycle_cnt(s_cycle_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic count_rst(output int c);
    c = 0;
    for (int g = 0; g < 20 && core_rst; g++) begin
      c++;
      tick();
    end
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_core_en", 32'(core_en), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_cnt", cycle_cnt, 32'd0);

    // Reset into run
    rst = 1'b0;
    count_rst(n);
    chk("rst_len", 32'(n), 32'd4);
    chk("run_state", 32'(state), 32'd1);
    chk("run_en", 32'(core_en), 32'd1);
    chk("run_cnt0", cycle_cnt, 32'd0);
    repeat (10) tick();
    chk("run_cnt10", cycle_cnt, 32'd10);
    chk("sat_cnt", 32'(s_cycle_cnt), 32'd7);

    // Halt
    pulse_restart();
    chk("halt_pre_state", 32'(state), 32'd1);
    repeat (7) tick();
    chk("halt_pre_cnt", cycle_cnt, 32'd7);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("halt_state", 32'(state), 32'd3);
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_en", 32'(core_en), 32'd0);
    chk("halt_cnt", cycle_cnt, 32'd8);
    step_req = 1'b1; run_mode = 1'b0; tick();
    step_req = 1'b0; tick();
    step_req = 1'b1; run_mode = 1'b1; tick();
    step_req = 1'b0; tick();
    chk("halt_hold_state", 32'(state), 32'd3);
    chk("halt_hold_cnt", cycle_cnt, 32'd8);
    chk("halt_hold_en", 32'(core_en), 32'd0);
    restart = 1'b1;
    repeat (3) tick();
    restart = 1'b0;
    chk("restart_state", 32'(state), 32'd0);
    chk("restart_halted", 32'(halted), 32'd0);
    chk("restart_cnt", cycle_cnt, 32'd0);
    count_rst(n);
    chk("restart_len", 32'(n), 32'd4);

    // Stepping
    run_mode = 1'b0;
    pulse_restart();
    chk("pause_state", 32'(state), 32'd2);
    chk("pause_en", 32'(core_en), 32'd0);
    chk("pause_core_rst", 32'(core_rst), 32'd0);
    n = 0;
    for (int p = 0; p < 3; p++) begin
      step_req = 1'b1;
      repeat (5) begin tick(); n += int'(core_en); end
      step_req = 1'b0;
      repeat (5) begin tick(); n += int'(core_en); end
    end
    chk("step_pulses", 32'(n), 32'd3);
    chk("step_cnt", cycle_cnt, 32'd3);
    chk("step_state", 32'(state), 32'd2);
    run_mode = 1'b1;
    tick();
    chk("resume_state", 32'(state), 32'd1);
    chk("resume_en", 32'(core_en), 32'd1);

    // Watchdog
    pulse_restart();
    n = 0;
    for (int g = 0; g < 100 && state == 2'b01; g++) begin
      n += int'(core_en);
      tick();
    end
    chk("wd_en_cycles", 32'(n), 32'd20);
    chk("wd_state", 32'(state), 32'd3);
    chk("wd_timeout", 32'(timeout), 32'd1);
    chk("wd_cnt", cycle_cnt, 32'd20);
    chk("wd_halted", 32'(halted), 32'd1);
    chk("nowd_state", 32'(s_state), 32'd1);
    chk("nowd_sat_cnt", 32'(s_cycle_cnt), 32'd7);

    // Collisions
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("restart_timeout", 32'(timeout), 32'd0);
    repeat (4) tick();
    halt = 1'b1; restart = 1'b1;
    tick();
    halt = 1'b0; restart = 1'b0;
    chk("coll_state", 32'(state), 32'd0);
    chk("coll_halted", 32'(halted), 32'd0);
    repeat (4) tick();
    chk("coll_run", 32'(state), 32'd1);
    halt = 1'b1; run_mode = 1'b0;
    tick();
    halt = 1'b0; run_mode = 1'b1;
    chk("halt_vs_pause", 32'(state), 32'd3);
    pulse_restart();
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_core_rst", 32'(core_rst), 32'd1);
    chk("midrst_en", 32'(core_en), 32'd0);
    chk("midrst_cnt", cycle_cnt, 32'd0);
    chk("midrst_halted", 32'(halted), 32'd0);
    chk("midrst_timeout", 32'(timeout), 32'd0);

`ifdef CPU_EXEC_CTRL_BKPT_EN
    bkpt_en = 1'b1;
    repeat (4) tick();
    for (int g = 0; g < 50 && state == 2'b01; g++) tick();
    chk("bkpt_state", 32'(state), 32'd2);
    chk("bkpt_hit", 32'(bkpt_hit), 32'd1);
    chk("bkpt_cnt", cycle_cnt, 32'd5);
    step_req = 1'b1;
    tick();
    chk("bkpt_step_en", 32'(core_en), 32'd1);
    tick();
    chk("bkpt_step_off", 32'(core_en), 32'd0);
    chk("bkpt_step_cnt", cycle_cnt, 32'd6);
    step_req = 1'b0;
    run_mode = 1'b1;
    tick();
    chk("bkpt_resume", 32'(state), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_exec_ctrl.md
Name: cpu_exec_ctrl

Overview:
- Execution sequencer for the RISC-V core inside the board wrapper.
- Generates the core's reset and clock-enable, and supports continuous run, single-step and halt.
- Counts enabled cycles and stops runaway programs with a watchdog.
- Sits between the board inputs (switches and buttons, already synchronized and debounced) and the core. Its status feeds the LED and seven-segment logic.

Parameters:
- RST_CYCLES, 4: number of cycles core_rst is held after entering RESET (minimum 1).
- CNT_W, 32: width of cycle_cnt.
- MAX_CYCLES, 0: watchdog limit in enabled cycles; 0 disables the watchdog.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset of this block.
- run_mode  in  1  1 = continuous run, 0 = single-step (pause).
- step_req  in  1  step request level; a rising edge requests one step.
- restart  in  1  level; while high, forces the core back through RESET.
- halt  in  1  core halt indication, sampled only in cycles where core_en=1.
- core_rst  out  1  reset to the core, registered.
- core_en  out  1  clock-enable to the core, registered.
- state  out  2  00 RESET, 01 RUN, 10 PAUSE, 11 HALT.
- halted  out  1  high in HALT.
- timeout  out  1  sticky; set when the watchdog fires.
- cycle_cnt  out  CNT_W  number of cycles with core_en=1 since the last RESET; saturates at all ones.

Behaviour:
- Single clock domain; reset is synchronous and active-high. Port names are clk and rst.
- Reset values (rst=1 at an edge): state=RESET, core_rst=1, core_en=0, halted=0, timeout=0, cycle_cnt=0, internal rst_cnt=0, step_q=0.
- Priority at each edge: rst > restart > watchdog > halt > mode/step.
- step_q <= step_req in every state. step_edge = step_req & ~step_q. An edge that occurs outside PAUSE is discarded.
- RESET:
  - core_rst=1, core_en=0, cycle_cnt=0, timeout=0.
  - rst_cnt counts 0..RST_CYCLES-1; core_rst stays high for exactly RST_CYCLES cycles.
  - Then moves to RUN if run_mode=1, otherwise PAUSE. core_rst=0 from the first cycle of the new state.
- RUN:
  - core_en=1 in every cycle.
  - halt=1 while core_en=1 -> HALT; core_en=0 from the next cycle.
  - run_mode=0 -> PAUSE; core_en=0 from the next cycle.
  - If halt and run_mode=0 occur together, HALT wins.
- PAUSE:
  - core_en=0, except a single-cycle pulse: step_edge at cycle n gives core_en=1 in cycle n+1 only.
  - halt sampled during that pulse cycle -> HALT.
  - run_mode=1 -> RUN; core_en=1 from the next cycle.
- HALT:
  - core_en=0, halted=1; cycle_cnt is frozen.
  - run_mode and step_req are ignored.
  - Exit only via restart or rst.
- restart=1 in any state -> RESET at the next edge, with rst_cnt cleared. While restart stays high, the block remains in RESET with rst_cnt held at 0.
- cycle_cnt increments at every edge ending a cycle with core_en=1. Saturates at all ones; never wraps.
- Watchdog (MAX_CYCLES>0):
  - Fires when core_en=1 and cycle_cnt==MAX_CYCLES-1 in the same cycle.
  - Next state is HALT with timeout=1, so exactly MAX_CYCLES enabled cycles execute.
  - Applies in both RUN and step pulses.
- rst asserted mid-operation: every output returns to its reset value at the next edge, regardless of state.

Optional Feature:
- Macro: CPU_EXEC_CTRL_BKPT_EN.
- Defined:
  - Adds inputs bkpt_en (1), bkpt_addr (32), pc (32) and output bkpt_hit (1). bkpt_hit is sticky and cleared by RESET or rst.
  - In RUN, when core_en=1 and bkpt_en=1 and pc==bkpt_addr: next state is PAUSE and bkpt_hit=1.
  - halt or the watchdog in the same cycle take priority (HALT).
  - Steps out of PAUSE proceed normally even if pc still equals bkpt_addr.
- Undefined: these ports and all breakpoint logic are absent; behaviour is exactly as above.

Test Plan:
- Reset into run: rst=1 for 3 cycles, then 0, with run_mode=1 -> core_rst=1 for exactly 4 cycles, then state=01 and core_en=1. After 10 further cycles, cycle_cnt=10.
- Halt: in RUN, halt=1 for 1 cycle at cnt=7 -> core_en=0 next cycle, state=11, halted=1, cycle_cnt=8 and frozen. Toggling step_req and run_mode has no effect. restart pulse -> core_rst=1 for 4 cycles, cycle_cnt=0, halted=0.
- Stepping: run_mode=0 after reset -> state=10, core_en=0. Three step_req pulses, each high 5 cycles -> exactly three 1-cycle core_en pulses and cycle_cnt=3. Setting run_mode=1 -> RUN on the next cycle.
- Watchdog: MAX_CYCLES=20 with run_mode=1 -> exactly 20 enabled cycles, then state=11, timeout=1, cycle_cnt=20.
- Collisions: halt=1 and restart=1 in the same cycle -> RESET (state=00), halted=0. rst=1 mid-RUN -> all outputs at reset values after 1 edge.
- With CPU_EXEC_CTRL_BKPT_EN: bkpt_addr=0x10 and pc walks 0x0,0x4,... -> PAUSE after the cycle with pc=0x10, bkpt_hit=1. One step advances one cycle; run_mode=1 resumes.
